// File: rtl/vm_pkg.sv
// Shared types for the vending-machine owner withdrawal path.
//   withdraw_status_t : result code reported in the log record and on status
//   wd_state_t        : withdrawal controller states
//   WAIT_CNT_W        : width of the response wait counter
package vm_pkg;

    localparam int unsigned WAIT_CNT_W = 8;

    typedef enum logic [2:0] {
        WD_OK         = 3'd0,
        WD_PARTIAL    = 3'd1,
        WD_INSUFF     = 3'd2,
        WD_OVER_LIMIT = 3'd3,
        WD_ZERO       = 3'd4,
        WD_TIMEOUT    = 3'd5
    } withdraw_status_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ_BAL = 3'd1,
        S_CHECK    = 3'd2,
        S_DEBIT    = 3'd3,
        S_LOG      = 3'd4,
        S_DONE     = 3'd5
    } wd_state_t;

endpackage

// File: rtl/wait_timer.sv
// Response wait counter for the withdrawal controller.
//   clock, reset_n : clock, async active-low reset
//   clear          : restart the count at zero
//   en             : count one waiting cycle
//   expired        : count has reached LIMIT-1 (registered)
module wait_timer
    import vm_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [WAIT_CNT_W-1:0] cnt;
    logic [WAIT_CNT_W-1:0] cnt_n;

    // Saturate at the expiry value so a stalled caller never wraps the count.
    always_comb begin
        cnt_n = cnt;
        if (clear) begin
            cnt_n = '0;
        end else if (en && !expired) begin
            cnt_n = cnt + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            expired <= (cnt_n == WAIT_CNT_W'(LIMIT - 1));
        end
    end

endmodule

// File: rtl/owner_withdraw_ctrl.sv
// Owner cash-withdrawal controller: reads the balance, checks the request
// against balance and per-transaction limit, debits the store, writes one
// log record and reports a status.
//   clock, reset_n                          : clock, async active-low reset
//   req_valid/req_ready/req_amount/req_partial : owner request handshake
//   bal_req/bal_valid/bal_value             : balance read
//   debit_valid/debit_ack/debit_amount      : debit command to the cash store
//   log_valid/log_ready/log_status/log_amount : log record
//   done/status/paid                        : completion pulse and held result
module owner_withdraw_ctrl
    import vm_pkg::*;
#(
    parameter int unsigned AMOUNT_W    = 8,
    parameter int unsigned MAX_TXN     = 200,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AMOUNT_W-1:0] req_amount,
    input  logic                req_partial,
    output logic                bal_req,
    input  logic                bal_valid,
    input  logic [AMOUNT_W-1:0] bal_value,
    output logic                debit_valid,
    output logic [AMOUNT_W-1:0] debit_amount,
    input  logic                debit_ack,
    output logic                log_valid,
    input  logic                log_ready,
    output logic [2:0]          log_status,
    output logic [AMOUNT_W-1:0] log_amount,
    output logic                done,
    output logic [2:0]          status,
    output logic [AMOUNT_W-1:0] paid
);

    localparam logic [AMOUNT_W-1:0] MAX_AMT = AMOUNT_W'(MAX_TXN);

    wd_state_t             state, state_n;
    withdraw_status_t      stat_q, stat_n;
    logic [AMOUNT_W-1:0]   amt_q, amt_n;
    logic [AMOUNT_W-1:0]   bal_q, bal_n;
    logic [AMOUNT_W-1:0]   pay_q, pay_n;
    logic                  part_q, part_n;
    logic                  tmr_clear, tmr_en, tmr_expired;

    wait_timer #(.LIMIT(TIMEOUT_CYC)) u_wait_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State register and transaction context.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            stat_q <= WD_OK;
            amt_q  <= '0;
            bal_q  <= '0;
            pay_q  <= '0;
            part_q <= 1'b0;
        end else begin
            state  <= state_n;
            stat_q <= stat_n;
            amt_q  <= amt_n;
            bal_q  <= bal_n;
            pay_q  <= pay_n;
            part_q <= part_n;
        end
    end

    // Next state, result selection and wait-timer control.
    always_comb begin
        state_n   = state;
        stat_n    = stat_q;
        amt_n     = amt_q;
        bal_n     = bal_q;
        pay_n     = pay_q;
        part_n    = part_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    amt_n  = req_amount;
                    part_n = req_partial;
                    pay_n  = '0;
                    if (req_amount == '0) begin
                        stat_n  = WD_ZERO;
                        state_n = S_LOG;
                    end else if (req_amount > MAX_AMT) begin
                        stat_n  = WD_OVER_LIMIT;
                        state_n = S_LOG;
                    end else begin
                        stat_n    = WD_OK;
                        state_n   = S_READ_BAL;
                        tmr_clear = 1'b1;
                    end
                end
            end
            S_READ_BAL: begin
                // A response in the expiry cycle still wins.
                if (bal_valid) begin
                    bal_n   = bal_value;
                    state_n = S_CHECK;
                end else if (tmr_expired) begin
                    stat_n  = WD_TIMEOUT;
                    pay_n   = '0;
                    state_n = S_LOG;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_CHECK: begin
                if (amt_q <= bal_q) begin
                    pay_n     = amt_q;
                    stat_n    = WD_OK;
                    state_n   = S_DEBIT;
                    tmr_clear = 1'b1;
                end else if (part_q && (bal_q != '0)) begin
                    pay_n     = bal_q;
                    stat_n    = WD_PARTIAL;
                    state_n   = S_DEBIT;
                    tmr_clear = 1'b1;
                end else begin
                    pay_n   = '0;
                    stat_n  = WD_INSUFF;
                    state_n = S_LOG;
                end
            end
            S_DEBIT: begin
                // On timeout the record shows nothing paid; the store reconciles.
                if (debit_ack) begin
                    state_n = S_LOG;
                end else if (tmr_expired) begin
                    stat_n  = WD_TIMEOUT;
                    pay_n   = '0;
                    state_n = S_LOG;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_LOG: begin
                if (log_ready) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the next state; payloads load on entry only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_ready    <= 1'b1;
            bal_req      <= 1'b0;
            debit_valid  <= 1'b0;
            debit_amount <= '0;
            log_valid    <= 1'b0;
            log_status   <= 3'd0;
            log_amount   <= '0;
            done         <= 1'b0;
            status       <= WD_OK;
            paid         <= '0;
        end else begin
            req_ready   <= (state_n == S_IDLE);
            bal_req     <= (state_n == S_READ_BAL);
            debit_valid <= (state_n == S_DEBIT);
            log_valid   <= (state_n == S_LOG);
            done        <= (state_n == S_DONE);
            if ((state_n == S_DEBIT) && (state != S_DEBIT)) begin
                debit_amount <= pay_n;
            end
            if ((state_n == S_LOG) && (state != S_LOG)) begin
                log_status <= stat_n;
                log_amount <= pay_n;
            end
            if ((state_n == S_DONE) && (state != S_DONE)) begin
                status <= stat_n;
                paid   <= pay_n;
            end
        end
    end

endmodule
